qsquare: RTL and testbench
==========================

Name: qsquare

Overview:
Sequential fixed-point squarer: the inverse operation of the Newton-iteration square-root block. It squares a sign-magnitude Q-format word using a shift-add engine that processes one magnitude bit per clock. It uses the same number format as the qadd/qdiv/qmulti family. It is used to check sqrt results (sqrted² ≈ sqrter) and to feed power/energy terms to downstream arithmetic.

Parameters:
N, 32, total word width; bit N-1 is sign, bits N-2..0 are magnitude.
Q, 15, number of fractional bits in the magnitude.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  reset.
start  input  1  request pulse; sampled only in IDLE.
squarer  input  N  operand (sign-magnitude, Q fractional bits).
busy  output  1  high while an operation is in progress.
valid  output  1  one-cycle pulse when squared/ovf are updated.
squared  output  N  result; sign bit always 0.
ovf  output  1  saturation flag for the last result; held until the next result.

Behaviour:
- Reset: rst_n is asynchronous, active-low.
  - While asserted: state=IDLE; busy, valid, ovf, squared, and the internal accumulator, counter and operand registers are all 0.
  - Asserting reset mid-operation aborts the operation. No valid pulse is produced for it.
- Operand handling:
  - The sign bit is discarded, since the square is always non-negative.
  - m = squarer[N-2:0] is latched at start.
  - Negative zero (0x80000000) squares to 0.
- Accumulator: acc is 2(N-1) bits wide (62 bits by default), with unsigned arithmetic.
- FSM IDLE:
  - busy=0.
  - When start=1, latch m, clear acc and cnt, set busy=1, and go to CALC.
  - squarer is don't-care after the start cycle.
- FSM CALC (N-1 cycles):
  - Each cycle: if m[cnt]=1 then acc += m << cnt; then cnt += 1.
  - When cnt reaches N-2, the final add is done that cycle and the FSM goes to DONE.
- FSM DONE (1 cycle):
  - Result field r = acc[Q+N-2:Q], i.e. truncation toward zero.
  - If acc[2N-3:Q+N-1] != 0, the result saturates: squared={1'b0,{N-1{1'b1}}} and ovf=1.
  - Otherwise: squared={1'b0,r} and ovf=0.
  - valid=1 for exactly this cycle; busy=0; the FSM returns to IDLE.
- Latency: start sampled at edge k → valid high after edge k+N (32 cycles by default). Throughput is one result per N+1 cycles at most.
- Output holding: squared and ovf hold their values until the next DONE.
- Start handling:
  - start while busy is ignored; nothing is queued.
  - start asserted in the cycle after the valid pulse (IDLE) is accepted normally.
  - A start held high continuously restarts immediately every time the FSM reaches IDLE.
- Edge cases: squarer=0 gives squared=0, ovf=0, with normal latency. There is no early termination.

Optional Feature:
Macro QSQUARE_ROUND_EN.
- Defined: round-to-nearest. r = acc[Q+N-2:Q] + acc[Q-1], i.e. ties round up.
  - If the increment carries out of N-1 bits, the result saturates and ovf=1.
  - Latency is unchanged.
- Undefined: truncation as described above. The rounding adder is absent.

Test Plan:
- Reset then start with squarer=0x00008000 (1.0) → after 32 cycles: valid pulse, squared=0x00008000, ovf=0; busy high for exactly 32 cycles.
- squarer=0x8000C000 (-1.5) → squared=0x00012000 (2.25), ovf=0. Then squarer=0x00004000 (0.5) → 0x00002000. Then 0x00010000 (2.0) → 0x00020000.
- squarer=0x00800000 (256.0) → squared=0x7FFFFFFF, ovf=1. A following 0x00008000 → ovf clears to 0 with that valid pulse.
- squarer=0x000000B5:
  - Macro undefined → 0x00000000.
  - QSQUARE_ROUND_EN defined → 0x00000001.
  - Also squarer=0x80000000 → 0x00000000.
- Start 0x00010000, re-pulse start with 0x00008000 at cycle 10 → ignored; the result is still 0x00020000.
- Start, then assert rst_n=0 at cycle 15 for 2 cycles → all outputs 0, no valid pulse. A new start completes normally.
- start held high across back-to-back operations → exactly one valid pulse every 33 cycles.

Source files
------------

// File: rtl/qsquare.sv
// Sequential sign-magnitude Q-format squarer: shift-add engine, one magnitude bit per clock.
// Optional macro QSQUARE_ROUND_EN selects round-to-nearest (ties up) instead of truncation.
module qsquare #(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] squarer,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] squared,
  output logic         ovf
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned AW = 2 * (N - 1);
  localparam int unsigned CW = $clog2(N - 1);
  localparam int unsigned HW = AW - (Q + MW);
  localparam int unsigned RW = MW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [MW-1:0]   m, m_d;
  logic [AW-1:0]   acc, acc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d, valid_d, ovf_d;
  logic [N-1:0]    squared_d;

  logic [HW-1:0]   hi;
  logic [MW-1:0]   r;
  logic            sat;
  logic            unused_sign;

  // The sign never matters: the square is always non-negative.
  assign unused_sign = squarer[N-1];
  assign hi          = acc[AW-1:Q+MW];

`ifdef QSQUARE_ROUND_EN
  logic [RW-1:0] r_rnd;
  // Half-LSB bit added in; a carry out of the field saturates like the high bits do.
  assign r_rnd = {1'b0, acc[Q+MW-1:Q]} + RW'(acc[Q-1]);
  assign r     = r_rnd[MW-1:0];
  assign sat   = (|hi) | r_rnd[MW];
`else
  assign r     = acc[Q+MW-1:Q];
  assign sat   = |hi;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      squared <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_d;
      m       <= m_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      valid   <= valid_d;
      squared <= squared_d;
      ovf     <= ovf_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    m_d       = m;
    acc_d     = acc;
    cnt_d     = cnt;
    busy_d    = busy;
    valid_d   = 1'b0;
    squared_d = squared;
    ovf_d     = ovf;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          m_d     = squarer[N-2:0];
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (m[cnt]) begin
          acc_d = acc + (AW'(m) << cnt);
        end
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(N - 2)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (sat) begin
          squared_d = {1'b0, {MW{1'b1}}};
          ovf_d     = 1'b1;
        end else begin
          squared_d = {1'b0, r};
          ovf_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_qsquare.sv
// Self-checking bench for qsquare: directed vector table plus hand-written multi-cycle sequences.
module tb_qsquare;

  localparam int unsigned N = 32;
  localparam int unsigned NV = 13;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] exp_sq;
    logic         exp_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] squarer;
  logic         busy;
  logic         valid;
  logic [N-1:0] squared;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qsquare #(.N(32), .Q(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .squarer(squarer),
    .busy   (busy),
    .valid  (valid),
    .squared(squared),
    .ovf    (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation: pulse start for one cycle, then wait (bounded) for valid.
  task automatic do_op(input logic [N-1:0] x, output logic [N-1:0] res, output logic o,
                       output int lat, output int busy_cyc);
    @(negedge clk);
    start   = 1'b1;
    squarer = x;
    @(negedge clk);
    start    = 1'b0;
    squarer  = $urandom;
    lat      = 0;
    busy_cyc = 0;
    while (!valid && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    res = squared;
    o   = ovf;
  endtask

  vec_t         vecs[NV];
  logic [N-1:0] res;
  logic         o;
  int           lat, bcyc, nvalid;
  int           vcyc[$];
  logic [N-1:0] b5_exp;

  initial begin
`ifdef QSQUARE_ROUND_EN
    b5_exp = 32'h0000_0001;
`else
    b5_exp = 32'h0000_0000;
`endif
    vecs[0]  = '{32'h0000_8000, 32'h0000_8000, 1'b0};
    vecs[1]  = '{32'h8000_C000, 32'h0001_2000, 1'b0};
    vecs[2]  = '{32'h0000_4000, 32'h0000_2000, 1'b0};
    vecs[3]  = '{32'h0001_0000, 32'h0002_0000, 1'b0};
    vecs[4]  = '{32'h0080_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[5]  = '{32'h0000_8000, 32'h0000_8000, 1'b0};
    vecs[6]  = '{32'h0000_00B5, b5_exp,        1'b0};
    vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'h0001_8000, 32'h0004_8000, 1'b0};
    vecs[10] = '{32'h007F_FFFF, 32'h7FFF_FE00, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[12] = '{32'h0000_0100, 32'h0000_0002, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    squarer = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {busy, valid, ovf, squared}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].x, res, o, lat, bcyc);
      check($sformatf("vec%0d squared", i), res, vecs[i].exp_sq);
      check($sformatf("vec%0d ovf", i), o, vecs[i].exp_ovf);
      check($sformatf("vec%0d latency", i), lat, 32);
      check($sformatf("vec%0d busy cycles", i), bcyc, 32);
    end

    // Saturated result and ovf hold in IDLE; the next good result clears ovf.
    do_op(32'h0080_0000, res, o, lat, bcyc);
    repeat (5) @(negedge clk);
    check("ovf hold", {valid, busy, ovf, squared}, {3'b001, 32'h7FFF_FFFF});
    do_op(32'h0000_8000, res, o, lat, bcyc);
    check("ovf clear", {o, res}, {1'b0, 32'h0000_8000});

    // A start pulse mid-operation is ignored and not queued.
    @(negedge clk);
    start   = 1'b1;
    squarer = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!valid && lat < 100) begin
      if (lat == 10) begin
        start   = 1'b1;
        squarer = 32'h0000_8000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy restart result", squared, 32'h0002_0000);
    check("busy restart latency", lat, 32);
    repeat (3) @(negedge clk);
    check("busy restart not queued", {valid, busy}, 2'b00);

    // Reset mid-operation aborts with no valid pulse.
    @(negedge clk);
    start   = 1'b1;
    squarer = 32'h0000_8000;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {busy, valid, ovf, squared}, '0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid || busy) nvalid++;
    end
    check("aborted op silent", nvalid, 0);
    do_op(32'h0001_8000, res, o, lat, bcyc);
    check("post reset result", {o, res}, {1'b0, 32'h0004_8000});
    check("post reset latency", lat, 32);

    // Start held high: back-to-back operations every N+1 cycles.
    @(negedge clk);
    start   = 1'b1;
    squarer = 32'h0000_4000;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (valid) begin
        vcyc.push_back(cyc);
        check("held start squared", squared, 32'h0000_2000);
      end
    end
    start = 1'b0;
    check("held start pulses", vcyc.size(), 3);
    for (int i = 1; i < vcyc.size(); i++) begin
      check($sformatf("held start gap%0d", i), vcyc[i] - vcyc[i-1], 33);
    end
    lat = 0;
    while (busy && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("drain bounded", lat < 60, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
